// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the prefetching instruction fetch unit:
// fetch FSM states and the instruction-length marker bit.
package ifetch_queue_pkg;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_FULL     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  // Set in the first word of an instruction when a second word follows.
  localparam int INSN_LONG_BIT = 0;

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus, redirect and decode-side signals of the fetch unit, bundled so the
// fetch unit (master) and its environment (slave) share one port.
interface ifetch_queue_if #(
  parameter int unsigned AW = 32
);
  // Handshakes: a bus word transfers on every rising edge where
  // bus_cyc && bus_ack (bus_in valid in that same cycle); an instruction is
  // consumed on every rising edge where ir_valid && !stall_i; pc_set is a
  // single-cycle command that always takes effect and overrides both.
  logic          bus_cyc;
  logic [AW-1:0] bus_adr;
  logic          bus_ack;
  logic [31:0]   bus_in;
  logic          pc_set;
  logic [AW-1:0] pc_in;
  logic          stall_i;
  logic [63:0]   ir;
  logic [AW-1:0] pc;
  logic          ir_valid;
  logic          stall_o;

  modport master (
    output bus_cyc, bus_adr, ir, pc, ir_valid, stall_o,
    input  bus_ack, bus_in, pc_set, pc_in, stall_i
  );

  modport slave (
    input  bus_cyc, bus_adr, ir, pc, ir_valid, stall_o,
    output bus_ack, bus_in, pc_set, pc_in, stall_i
  );

endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// Prefetch word queue: DEPTH x 32 circular buffer exposing the head word and
// the one behind it so a two-word instruction can be popped in one cycle.
module ifetch_queue_fetch_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [31:0]   wdata_i,
  input  logic          pop1_i,
  input  logic          pop2_i,
  input  logic          flush_i,
  output logic [31:0]   head_o,
  output logic [31:0]   head1_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_d_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pop_cnt;

  // DEPTH is a power of two, so pointer overflow is the wrap-around.
  always_comb begin
    pop_cnt  = pop2_i ? CW'(2) : (pop1_i ? CW'(1) : '0);
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
    count_d  = count_q + CW'(push_i) - pop_cnt;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign head1_o   = mem_q[rd_ptr_q + PW'(1)];
  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: streams bus words into a prefetch queue, assembles
// 32/64-bit instructions at its head and redirects on a later-stage branch.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ifetch_queue_if.master bus,
  output state_t         state_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t        state_q;
  logic [AW-1:0] fetch_adr_q;
  logic [AW-1:0] head_pc_q;
  logic [63:0]   ir_q;
  logic [AW-1:0] pc_q;
  logic          ir_valid_q;

  logic [31:0]   head, head1;
  logic [CW-1:0] count, count_d;
  logic          is_long, avail, load, push, pop1, pop2;
  logic [AW-1:0] target;

  // Only words already queued at the start of the cycle can be issued.
  assign is_long = head[INSN_LONG_BIT];
  assign avail   = is_long ? (count >= CW'(2)) : (count != '0);
  assign load    = avail && (!ir_valid_q || !bus.stall_i) && !bus.pc_set;
  assign push    = (state_q == S_FETCH) && bus.bus_ack && !bus.pc_set;
  assign pop1    = load && !is_long;
  assign pop2    = load && is_long;
  assign target  = bus.pc_in & ~AW'(3);

  ifetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .wdata_i   (bus.bus_in),
    .pop1_i    (pop1),
    .pop2_i    (pop2),
    .flush_i   (bus.pc_set),
    .head_o    (head),
    .head1_o   (head1),
    .count_o   (count),
    .count_d_o (count_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_FETCH;
      fetch_adr_q <= RESET_PC;
      head_pc_q   <= RESET_PC;
      ir_q        <= '0;
      pc_q        <= RESET_PC;
      ir_valid_q  <= 1'b0;
    end else if (bus.pc_set) begin
      // Redirect wins over stall and ack; a word acked now is dropped.
      state_q     <= S_REDIRECT;
      fetch_adr_q <= target;
      head_pc_q   <= target;
      ir_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH:    if (count_d == CW'(DEPTH)) state_q <= S_FULL;
        S_FULL:     if (count_d < CW'(DEPTH))  state_q <= S_FETCH;
        S_REDIRECT: state_q <= S_FETCH;
        default:    state_q <= S_FETCH;
      endcase
      if (push) fetch_adr_q <= fetch_adr_q + AW'(4);
      if (load) begin
        ir_q       <= is_long ? {head1, head} : {32'h0, head};
        pc_q       <= head_pc_q;
        head_pc_q  <= head_pc_q + (is_long ? AW'(8) : AW'(4));
        ir_valid_q <= 1'b1;
      end else if (!bus.stall_i) begin
        ir_valid_q <= 1'b0;
      end
    end
  end

  assign bus.bus_cyc  = (state_q == S_FETCH);
  assign bus.bus_adr  = fetch_adr_q;
  assign bus.ir       = ir_q;
  assign bus.pc       = pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.stall_o  = !ir_valid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: zero-wait/withheld-ack slave, stalls,
// redirects and asynchronous reset, each scenario with hand-derived values.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   ack_en = 1'b0;
  state_t state;
  int     checks = 0;
  int     errors = 0;
  logic [31:0] mem [256];

  ifetch_queue_if #(.AW(32)) bus_if ();

  ifetch_queue #(.AW(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus_if),
    .state_o (state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Zero-wait slave backed by a 256-word memory image
  always_comb begin
    bus_if.bus_ack = ack_en && bus_if.bus_cyc;
    bus_if.bus_in  = mem[bus_if.bus_adr[9:2]];
  end

  function automatic logic [31:0] exp_word(input int idx);
    return 32'hC000_0000 + (idx << 4);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = exp_word(i);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Asserts reset, applies inputs, releases on a falling edge (start of cycle 0).
  task automatic do_reset(input logic ack, input logic stall);
    @(negedge clk);
    rst = 1'b1;
    fill_mem();
    bus_if.pc_set  = 1'b0;
    bus_if.pc_in   = '0;
    bus_if.stall_i = stall;
    ack_en         = ack;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.pc_set  = 1'b0;
    bus_if.pc_in   = '0;
    bus_if.stall_i = 1'b0;
    fill_mem();
    @(negedge clk);
    checks++; if (bus_if.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b want 0", bus_if.ir_valid); end
    checks++; if (bus_if.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus_if.pc); end
    checks++; if (bus_if.ir !== 64'h0) begin errors++; $display("FAIL reset_ir got %h want 0", bus_if.ir); end
    checks++; if (bus_if.stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_o got %b want 1", bus_if.stall_o); end
    checks++; if (state !== S_FETCH) begin errors++; $display("FAIL reset_state got %0d want %0d", state, S_FETCH); end
  endtask

  task automatic test_short();
    do_reset(1'b1, 1'b0);
    mem[0] = 32'h0000_0010;
    mem[1] = 32'h0000_0020;
    #1;
    checks++; if (bus_if.bus_cyc !== 1'b1 || bus_if.bus_adr !== 32'h0) begin errors++; $display("FAIL short_cycle0 got cyc=%b adr=%h want cyc=1 adr=0", bus_if.bus_cyc, bus_if.bus_adr); end
    tick();
    checks++; if (bus_if.ir_valid !== 1'b0 || bus_if.bus_adr !== 32'h4) begin errors++; $display("FAIL short_cycle1 got v=%b adr=%h want v=0 adr=4", bus_if.ir_valid, bus_if.bus_adr); end
    tick();
    checks++; if (bus_if.ir_valid !== 1'b1 || bus_if.ir !== 64'h10 || bus_if.pc !== 32'h0 || bus_if.bus_adr !== 32'h8) begin
      errors++; $display("FAIL short_first got v=%b ir=%h pc=%h adr=%h want v=1 ir=10 pc=0 adr=8", bus_if.ir_valid, bus_if.ir, bus_if.pc, bus_if.bus_adr); end
    tick();
    checks++; if (bus_if.ir !== 64'h20 || bus_if.pc !== 32'h4) begin errors++; $display("FAIL short_second got ir=%h pc=%h want ir=20 pc=4", bus_if.ir, bus_if.pc); end
    tick();
    checks++; if (bus_if.ir !== {32'h0, exp_word(2)} || bus_if.pc !== 32'h8) begin errors++; $display("FAIL short_third got ir=%h pc=%h want ir=%h pc=8", bus_if.ir, bus_if.pc, exp_word(2)); end
  endtask

  task automatic test_long();
    do_reset(1'b1, 1'b0);
    mem[0] = 32'h0000_0011;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'h0000_0030;
    tick(); tick();
    checks++; if (bus_if.ir_valid !== 1'b0) begin errors++; $display("FAIL long_wait got v=%b want 0", bus_if.ir_valid); end
    tick();
    checks++; if (bus_if.ir_valid !== 1'b1 || bus_if.ir !== 64'hDEADBEEF_00000011 || bus_if.pc !== 32'h0) begin
      errors++; $display("FAIL long_issue got v=%b ir=%h pc=%h want v=1 ir=deadbeef00000011 pc=0", bus_if.ir_valid, bus_if.ir, bus_if.pc); end
    tick();
    checks++; if (bus_if.ir !== 64'h30 || bus_if.pc !== 32'h8) begin errors++; $display("FAIL long_next got ir=%h pc=%h want ir=30 pc=8", bus_if.ir, bus_if.pc); end
  endtask

  task automatic test_long_withheld();
    do_reset(1'b1, 1'b0);
    mem[0] = 32'h0000_0011;
    mem[1] = 32'hDEAD_BEEF;
    tick();
    ack_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (bus_if.ir_valid !== 1'b0) begin errors++; $display("FAIL withheld_cycle%0d got v=%b want 0", k, bus_if.ir_valid); end
      if (k < 6) tick();
    end
    ack_en = 1'b1;
    tick();
    checks++; if (bus_if.ir_valid !== 1'b0) begin errors++; $display("FAIL withheld_resume got v=%b want 0", bus_if.ir_valid); end
    tick();
    checks++; if (bus_if.ir_valid !== 1'b1 || bus_if.ir !== 64'hDEADBEEF_00000011 || bus_if.pc !== 32'h0) begin
      errors++; $display("FAIL withheld_issue got v=%b ir=%h pc=%h want v=1 ir=deadbeef00000011 pc=0", bus_if.ir_valid, bus_if.ir, bus_if.pc); end
  endtask

  task automatic test_stall_full();
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) begin
        checks++; if (bus_if.bus_cyc !== 1'b1) begin errors++; $display("FAIL full_not_yet got cyc=%b want 1", bus_if.bus_cyc); end
      end
      if (k == 5 || k == 10) begin
        checks++; if (bus_if.bus_cyc !== 1'b0 || state !== S_FULL) begin errors++; $display("FAIL full_cycle%0d got cyc=%b state=%0d want cyc=0 state=%0d", k, bus_if.bus_cyc, state, S_FULL); end
      end
    end
    checks++; if (bus_if.ir_valid !== 1'b1 || bus_if.ir !== {32'h0, exp_word(0)} || bus_if.pc !== 32'h0 || bus_if.bus_adr !== 32'h14) begin
      errors++; $display("FAIL full_hold got v=%b ir=%h pc=%h adr=%h want v=1 ir=%h pc=0 adr=14", bus_if.ir_valid, bus_if.ir, bus_if.pc, bus_if.bus_adr, exp_word(0)); end
    bus_if.stall_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (bus_if.bus_cyc !== 1'b1) begin errors++; $display("FAIL full_refetch got cyc=%b want 1", bus_if.bus_cyc); end
      end
      checks++; if (bus_if.ir !== {32'h0, exp_word(k)} || bus_if.pc !== 32'(4 * k)) begin
        errors++; $display("FAIL drain_%0d got ir=%h pc=%h want ir=%h pc=%h", k, bus_if.ir, bus_if.pc, exp_word(k), 4 * k); end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b1);
    repeat (4) tick();
    bus_if.pc_set = 1'b1;
    bus_if.pc_in  = 32'h0000_0103;
    tick();
    bus_if.pc_set  = 1'b0;
    bus_if.stall_i = 1'b0;
    checks++; if (bus_if.ir_valid !== 1'b0 || bus_if.bus_cyc !== 1'b0 || state !== S_REDIRECT) begin
      errors++; $display("FAIL redir_flush got v=%b cyc=%b state=%0d want v=0 cyc=0 state=%0d", bus_if.ir_valid, bus_if.bus_cyc, state, S_REDIRECT); end
    tick();
    checks++; if (bus_if.bus_cyc !== 1'b1 || bus_if.bus_adr !== 32'h100) begin errors++; $display("FAIL redir_fetch got cyc=%b adr=%h want cyc=1 adr=100", bus_if.bus_cyc, bus_if.bus_adr); end
    tick();
    checks++; if (bus_if.ir_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got v=%b want 0", bus_if.ir_valid); end
    tick();
    checks++; if (bus_if.ir_valid !== 1'b1 || bus_if.pc !== 32'h100 || bus_if.ir !== {32'h0, exp_word(64)}) begin
      errors++; $display("FAIL redir_first got v=%b pc=%h ir=%h want v=1 pc=100 ir=%h", bus_if.ir_valid, bus_if.pc, bus_if.ir, exp_word(64)); end
    tick();
    checks++; if (bus_if.pc !== 32'h104 || bus_if.ir !== {32'h0, exp_word(65)}) begin
      errors++; $display("FAIL redir_second got pc=%h ir=%h want pc=104 ir=%h", bus_if.pc, bus_if.ir, exp_word(65)); end
  endtask

  task automatic test_double_redirect();
    do_reset(1'b1, 1'b0);
    repeat (3) tick();
    bus_if.pc_set = 1'b1;
    bus_if.pc_in  = 32'h0000_0080;
    tick();
    checks++; if (bus_if.bus_cyc !== 1'b0) begin errors++; $display("FAIL dredir_first got cyc=%b want 0", bus_if.bus_cyc); end
    bus_if.pc_in = 32'h0000_0200;
    tick();
    bus_if.pc_set = 1'b0;
    checks++; if (bus_if.bus_cyc !== 1'b0 || state !== S_REDIRECT) begin
      errors++; $display("FAIL dredir_restart got cyc=%b state=%0d want cyc=0 state=%0d", bus_if.bus_cyc, state, S_REDIRECT); end
    tick();
    checks++; if (bus_if.bus_cyc !== 1'b1 || bus_if.bus_adr !== 32'h200) begin errors++; $display("FAIL dredir_fetch got cyc=%b adr=%h want cyc=1 adr=200", bus_if.bus_cyc, bus_if.bus_adr); end
    tick(); tick();
    checks++; if (bus_if.ir_valid !== 1'b1 || bus_if.pc !== 32'h200 || bus_if.ir !== {32'h0, exp_word(128)}) begin
      errors++; $display("FAIL dredir_issue got v=%b pc=%h ir=%h want v=1 pc=200 ir=%h", bus_if.ir_valid, bus_if.pc, bus_if.ir, exp_word(128)); end
    tick();
    checks++; if (bus_if.pc !== 32'h204) begin errors++; $display("FAIL dredir_next got pc=%h want 204", bus_if.pc); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    checks++; if (bus_if.ir_valid !== 1'b1 || bus_if.pc !== 32'h8) begin errors++; $display("FAIL arst_before got v=%b pc=%h want v=1 pc=8", bus_if.ir_valid, bus_if.pc); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_if.ir_valid !== 1'b0 || bus_if.pc !== 32'h0 || bus_if.ir !== 64'h0 || bus_if.stall_o !== 1'b1 || bus_if.bus_adr !== 32'h0) begin
      errors++; $display("FAIL arst_immediate got v=%b pc=%h ir=%h stall=%b adr=%h want v=0 pc=0 ir=0 stall=1 adr=0",
                         bus_if.ir_valid, bus_if.pc, bus_if.ir, bus_if.stall_o, bus_if.bus_adr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_long_withheld();
    test_stall_full();
    test_redirect();
    test_double_redirect();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction fetch unit with a prefetch word queue, replacing the single-word fetcher in the bexkat1 front end. It streams 32-bit words from the instruction bus into a DEPTH-word FIFO, independently of decode stalls. It assembles 32- or 64-bit instructions from the FIFO head, where bit 0 of the first word set means a second word follows. It presents each instruction with its own address to decode, and flushes and redirects on a branch from a later stage.

## Interface
- AW, 32: address width; pc, pc_in, bus_adr width.
- DEPTH, 4: queue depth in 32-bit words; power of two, ≥2.
- RESET_PC, 32'h0: fetch and pc value after reset; word aligned.
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- bus_cyc  out  1  fetch request; a word transfers on any cycle with bus_cyc && bus_ack.
- bus_adr  out  AW  word address of current request; bits [1:0] always 0.
- bus_ack  in  1  slave ack; bus_in is valid in the same cycle.
- bus_in  in  32  fetched word.
- pc_set  in  1  redirect request from a later stage.
- pc_in  in  AW  redirect target; bits [1:0] ignored and forced to 0.
- stall_i  in  1  decode cannot accept an instruction this cycle.
- ir  out  64  instruction; [31:0] first word, [63:32] second word or 0.
- pc  out  AW  address of ir's first word.
- ir_valid  out  1  ir/pc hold an unconsumed instruction.
- stall_o  out  1  equals !ir_valid (fetch bubble to decode).

## Operation
- Reset: state=S_FETCH, fetch_adr=RESET_PC, head_pc=RESET_PC, count=0, ir=64'h0, pc=RESET_PC, ir_valid=0. bus_cyc=1 from the first cycle after reset.
- FSM states:
  - S_FETCH: bus_cyc=1.
  - S_FULL: bus_cyc=0; the queue cannot accept a word.
  - S_REDIRECT: bus_cyc=0 for exactly one cycle, so the slave sees the old cycle end.
- FSM transitions:
  - S_FETCH→S_FULL when next count==DEPTH.
  - S_FULL→S_FETCH when next count<DEPTH.
  - Any state→S_REDIRECT on pc_set.
  - S_REDIRECT→S_FETCH unconditionally.
- Push: in S_FETCH with bus_ack, bus_in is written at the tail and fetch_adr+=4. bus_adr=fetch_adr. Address arithmetic is modulo 2^AW (wraps silently).
- Instruction available when count≥1 and head[0]==0 (short), or count≥2 and head[0]==1 (long). Only words present at the start of the cycle count; a push never bypasses into the output in the same cycle.
- Load: the output register loads when available && (!ir_valid || !stall_i):
  - short: ir={32'h0,head}, pop 1.
  - long: ir={head+1,head}, pop 2.
  - In both cases pc=head_pc and head_pc+=4 per popped word.
- Drain: if !stall_i and nothing is available, ir_valid<=0.
- count_next = count + push − pops. Simultaneous push and pop are legal, including at full: a pop frees a slot that is usable the next cycle, not the same cycle.
- Redirect (pc_set=1) has priority over everything, including stall_i and bus_ack:
  - queue flushed (count=0), ir_valid<=0, fetch_adr<=pc_in&~3, head_pc<=pc_in&~3;
  - any word acked that cycle is discarded.
- pc_set while in S_REDIRECT restarts the redirect with the new target.
- Long instruction at the queue head with only one word present: wait, no bubble-skipping, no partial issue.

## Timing
- Ack-to-decode latency 2 cycles: word acked in cycle n → in queue at n+1 → ir_valid at n+2.
- After reset release: bus_adr=RESET_PC in cycle 0; with a zero-wait slave, ir_valid=1 in cycle 2.
- pc_set in cycle n:
  - n+1: bus_cyc=0;
  - n+2: bus_cyc=1 with bus_adr=target;
  - zero-wait ack at n+2 gives ir_valid at n+4.
- Peak throughput: one short instruction per cycle with a zero-wait slave. A long instruction costs 2 bus words.
- Outputs ir/pc/ir_valid are registered. bus_cyc, bus_adr and stall_o are derived from registers only (no combinational path from inputs).

## Structure
- Shared bexkat1Def package gets:
  - fetch state_t enum {S_FETCH, S_FULL, S_REDIRECT};
  - localparam INSN_LONG_BIT=0.
- Sub-module fetch_fifo:
  - DEPTH×32 storage with read/write pointers and count;
  - push, pop1, pop2 and flush inputs;
  - head and head+1 outputs.
- ifetch_queue holds the FSM, fetch_adr, head_pc and the output register.

## Test plan
- Reset, zero-wait slave returning 0x00000010,0x00000020 → bus_adr 0,4,8…; ir_valid cycle 2 with ir=0x0000000000000010, pc=0; next cycle ir=0x20, pc=4.
- Long instruction: words 0x00000011, 0xDEADBEEF at 0/4 → ir=0xDEADBEEF00000011, pc=0, next pc=8. With ack withheld for the second word, ir_valid stays 0.
- stall_i held high for 10 cycles (DEPTH=4) → 4 words queued, then bus_cyc=0 (S_FULL). ir/pc unchanged. Release stall_i → one instruction per cycle, bus_cyc=1 again a cycle after the first pop.
- pc_set with pc_in=0x00000103 while the queue holds 3 words and ack is high → acked word dropped, ir_valid=0 next cycle, one-cycle bus_cyc=0, then bus_adr=0x100, first ir has pc=0x100.
- pc_set during S_REDIRECT, then again with target 0x200 → fetch resumes at 0x200 only.
- rst_i asserted mid-fetch, asynchronously between edges → all outputs immediately at reset values (ir_valid=0, pc=RESET_PC).
